nios2_freertos_ledr_pio: RTL and testbench

Avalon-MM slave output port driving the DE2-115 red LEDs from the Nios II FreeRTOS system; the write-side counterpart of the switch input port. Software writes an 18-bit output image directly or through atomic bit-set/bit-clear registers. A hardware blink engine periodically blanks a masked subset of bits without CPU involvement. Sits on the system interconnect next to the switch PIO; `out_port` is exported to top-level LEDR pins.

---
 rtl/nios2_freertos_ledr_pio_pkg.sv | 14 +
 rtl/nios2_freertos_ledr_blink_timer.sv | 34 +++
 rtl/nios2_freertos_ledr_pio.sv | 105 ++++++++++
 tb/tb_nios2_freertos_ledr_pio.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/nios2_freertos_ledr_pio_pkg.sv
// Shared register map for the red-LED output PIO.
// Offsets are word addresses on the Avalon-MM slave port.
package nios2_freertos_ledr_pio_pkg;

    localparam logic [2:0] ADDR_DATA       = 3'd0;
    localparam logic [2:0] ADDR_BLINK_MASK = 3'd1;
    localparam logic [2:0] ADDR_BLINK_DIV  = 3'd2;
    localparam logic [2:0] ADDR_STATUS     = 3'd3;
    localparam logic [2:0] ADDR_OUTSET     = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR   = 3'd5;

    localparam int STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/nios2_freertos_ledr_blink_timer.sv
// Blink prescaler: phase toggles every div+1 cycles while div is non-zero.
// A load restarts the period with phase cleared and wins over a same-cycle toggle.
module nios2_freertos_ledr_blink_timer #(
    parameter int DIV_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 div_load,
    output logic                 phase
);

    logic [DIV_WIDTH-1:0] cnt;

    // cnt only ever reaches a new period through the reload, never by underflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (div_load) begin
            cnt   <= div;
            phase <= 1'b0;
        end else if (div == '0) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == '0) begin
            cnt   <= div;
            phase <= ~phase;
        end else begin
            cnt   <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/nios2_freertos_ledr_pio.sv
// Avalon-MM output PIO driving the DE2-115 red LEDs, with atomic set/clear
// registers and a hardware blink engine that blanks masked bits.
module nios2_freertos_ledr_pio
    import nios2_freertos_ledr_pio_pkg::*;
#(
    parameter int               WIDTH       = 18,
    parameter int               DIV_WIDTH   = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [2:0]       address,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]     data_q;
    logic [WIDTH-1:0]     mask_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [WIDTH-1:0]     data_nxt;
    logic [WIDTH-1:0]     mask_nxt;
    logic [DIV_WIDTH-1:0] div_nxt;
    logic                 div_load;
    logic                 phase;
    logic                 wr_en;
    logic [WIDTH-1:0]     wd_w;
    logic [DIV_WIDTH-1:0] wd_div;
    logic [31:0]          readdata_nxt;
    logic                 unused_ok;

    assign wr_en     = chipselect && !write_n;
    assign wd_w      = writedata[WIDTH-1:0];
    assign wd_div    = writedata[DIV_WIDTH-1:0];
    assign unused_ok = &{1'b0, writedata};

    // OUTSET/OUTCLEAR modify the current DATA in one cycle, so back-to-back
    // accesses compose without a read from software.
    always_comb begin
        data_nxt = data_q;
        mask_nxt = mask_q;
        div_nxt  = div_q;
        div_load = 1'b0;
        if (wr_en) begin
            case (address)
                ADDR_DATA:       data_nxt = wd_w;
                ADDR_BLINK_MASK: mask_nxt = wd_w;
                ADDR_BLINK_DIV: begin
                    div_nxt  = wd_div;
                    div_load = 1'b1;
                end
                ADDR_OUTSET:     data_nxt = data_q | wd_w;
                ADDR_OUTCLEAR:   data_nxt = data_q & ~wd_w;
                default:         ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
            mask_q <= '0;
            div_q  <= '0;
        end else begin
            data_q <= data_nxt;
            mask_q <= mask_nxt;
            div_q  <= div_nxt;
        end
    end

    // div_nxt carries the freshly written value on a load and div_q otherwise
    nios2_freertos_ledr_blink_timer #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_blink_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .div      (div_nxt),
        .div_load (div_load),
        .phase    (phase)
    );

    always_comb begin
        readdata_nxt = '0;
        case (address)
            ADDR_DATA:       readdata_nxt[WIDTH-1:0]        = data_q;
            ADDR_BLINK_MASK: readdata_nxt[WIDTH-1:0]        = mask_q;
            ADDR_BLINK_DIV:  readdata_nxt[DIV_WIDTH-1:0]    = div_q;
            ADDR_STATUS:     readdata_nxt[STATUS_PHASE_BIT] = phase;
            default:         ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            out_port <= RESET_VALUE;
        end else begin
            readdata <= readdata_nxt;
            out_port <= data_q & ~(mask_q & {WIDTH{phase}});
        end
    end

endmodule

// File: tb/tb_nios2_freertos_ledr_pio.sv
// Bench for the red-LED PIO: directed register/blink/reset scenarios and a
// randomized run, checked every cycle against a period-arithmetic model.
module tb_nios2_freertos_ledr_pio;

    localparam int          W   = 18;
    localparam int          DW  = 24;
    localparam logic [W-1:0] RV = 18'h00015;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [2:0]    address = 3'd0;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic [W-1:0]  out_port;

    int checks = 0;
    int failures = 0;

    nios2_freertos_ledr_pio #(
        .WIDTH       (W),
        .DIV_WIDTH   (DW),
        .RESET_VALUE (RV)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .write_n    (write_n),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    // Model: registers plus the edge index of the last BLINK_DIV write;
    // phase is derived from elapsed edges divided by the period length.
    logic [W-1:0]  m_data = RV;
    logic [W-1:0]  m_mask = '0;
    logic [DW-1:0] m_div = '0;
    longint        edge_cnt = 0;
    longint        load_edge = 0;
    logic [W-1:0]  exp_q[$];
    logic [31:0]   exp_rd_q[$];

    function automatic logic model_phase(input longint k);
        if (m_div == '0) return 1'b0;
        return (((k - load_edge) / (longint'(m_div) + 1)) % 2) != 0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        logic        pre_ph;
        logic [31:0] rd;
        if (!reset_n) begin
            m_data = RV;
            m_mask = '0;
            m_div  = '0;
            exp_q.delete();
            exp_rd_q.delete();
        end else begin
            pre_ph = model_phase(edge_cnt);
            exp_q.push_back(m_data & ~(m_mask & {W{pre_ph}}));
            case (address)
                3'd0:    rd = 32'(m_data);
                3'd1:    rd = 32'(m_mask);
                3'd2:    rd = 32'(m_div);
                3'd3:    rd = {31'd0, pre_ph};
                default: rd = 32'd0;
            endcase
            exp_rd_q.push_back(rd);
            edge_cnt = edge_cnt + 1;
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_data = writedata[W-1:0];
                    3'd1: m_mask = writedata[W-1:0];
                    3'd2: begin
                        m_div     = writedata[DW-1:0];
                        load_edge = edge_cnt;
                    end
                    3'd4: m_data = m_data | writedata[W-1:0];
                    3'd5: m_data = m_data & ~writedata[W-1:0];
                    default: ;
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [31:0]  er;
        if (reset_n && exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            er = exp_rd_q.pop_front();
            chk("model_out_port", 32'(out_port), 32'(e));
            chk("model_readdata", readdata, er);
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
    endtask

    task automatic idle(input logic [2:0] a);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = a;
        writedata  = $urandom;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp_rd,
                      input logic [31:0] exp_out, input string name);
        idle(a);
        @(posedge clk);
        #1;
        chk({name, "_rd"}, readdata, exp_rd);
        chk({name, "_out"}, 32'(out_port), exp_out);
    endtask

    initial begin
        logic ph;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_port", 32'(out_port), 32'h00015);
        chk("reset_readdata", readdata, 32'h0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        rd(3'd0, 32'h00015, 32'h00015, "reset_read_data");

        wr(3'd0, 32'h0003FFFF);
        wr(3'd5, 32'h0000000F);
        wr(3'd4, 32'h00020000);
        rd(3'd0, 32'h0003FFF0, 32'h0003FFF0, "setclr");

        wr(3'd1, 32'h000000FF);
        wr(3'd0, 32'h0003FFFF);
        wr(3'd2, 32'd3);
        for (int i = 0; i < 16; i++) begin
            ph = ((i / 4) % 2) != 0;
            rd(3'd3, {31'd0, ph}, ph ? 32'h0003FF00 : 32'h0003FFFF, "blink3");
        end

        wr(3'd2, 32'd3);
        for (int i = 0; i < 3; i++) rd(3'd3, 32'd0, 32'h0003FFFF, "pre_reload");
        wr(3'd2, 32'd5);
        for (int j = 0; j < 12; j++) begin
            ph = ((j / 6) % 2) != 0;
            rd(3'd3, {31'd0, ph}, ph ? 32'h0003FF00 : 32'h0003FFFF, "blink5");
        end
        wr(3'd2, 32'd0);
        for (int i = 0; i < 4; i++) rd(3'd0, 32'h0003FFFF, 32'h0003FFFF, "div0_steady");

        wr(3'd0, 32'h00012345);
        wr(3'd6, 32'hFFFFFFFF);
        wr(3'd7, 32'hFFFFFFFF);
        rd(3'd0, 32'h00012345, 32'h00012345, "resv_data");
        rd(3'd1, 32'h000000FF, 32'h00012345, "resv_mask");
        rd(3'd2, 32'h00000000, 32'h00012345, "resv_div");
        for (int a = 4; a < 8; a++) rd(3'(a), 32'h0, 32'h00012345, "wo_read");

        wr(3'd0, 32'h0003FFFF);
        wr(3'd2, 32'd1);
        rd(3'd3, 32'd0, 32'h0003FFFF, "pre_rst0");
        rd(3'd3, 32'd0, 32'h0003FFFF, "pre_rst1");
        rd(3'd3, 32'd1, 32'h0003FF00, "pre_rst2");
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midblink_reset_out", 32'(out_port), 32'h00015);
        chk("midblink_reset_rd", readdata, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 12; i++) rd(3'd3, 32'd0, 32'h00015, "post_reset");

        for (int n = 0; n < 1500; n++) begin
            logic [2:0] a;
            a = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 6) begin
                if (a == 3'd2)
                    wr(a, ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 6)));
                else
                    wr(a, $urandom);
            end else begin
                idle(a);
            end
        end
        idle(3'd0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
